// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry and
// the parity-mode encoding used by both receive and transmit paths.
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_BITS  = 8;
  localparam int unsigned DEFAULT_OVERSAMPLE = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'b00,
    PARITY_EVEN = 2'b10,
    PARITY_ODD  = 2'b11
  } parity_mode_t;

  function automatic parity_mode_t parity_mode(input logic en, input logic odd);
    parity_mode_t m;
    m = PARITY_NONE;
    if (en) m = odd ? PARITY_ODD : PARITY_EVEN;
    return m;
  endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input, with the synchronised
// level and a one-clk pulse on each synchronised rising edge.
module uart_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= RESET_VAL ? '1 : '0;
      prev_r <= RESET_VAL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign rise  = level & ~prev_r;

endmodule

// File: rtl/uart_rx_oversampler.sv
// Oversampling UART receiver for 8N1/8E1/8O1 frames, clocked by clk and
// advanced by ticks derived from the baud generator's rx_clk square wave.
module uart_rx_oversampler
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int unsigned OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_clk,
  input  logic                 rx_in,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic tick, rx_s;
  logic unused_rx_clk_level, unused_rx_in_rise;

  uart_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_clk),
    .level (unused_rx_clk_level),
    .rise  (tick)
  );

  uart_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_in),
    .level (rx_s),
    .rise  (unused_rx_in_rise)
  );

  rx_state_t              state_r, state_n;
  logic [CNT_W-1:0]       cnt_r, cnt_n;
  logic [IDX_W-1:0]       idx_r, idx_n;
  logic [DATA_BITS-1:0]   shift_r, shift_n;
  parity_mode_t           mode_r, mode_n;
  logic                   perr_r, perr_n;
  logic [DATA_BITS-1:0]   data_n;
  logic                   valid_n, parity_err_n, framing_err_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      idx_r       <= '0;
      shift_r     <= '0;
      mode_r      <= PARITY_NONE;
      perr_r      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      idx_r       <= idx_n;
      shift_r     <= shift_n;
      mode_r      <= mode_n;
      perr_r      <= perr_n;
      rx_data     <= data_n;
      rx_valid    <= valid_n;
      parity_err  <= parity_err_n;
      framing_err <= framing_err_n;
    end
  end

  always_comb begin
    state_n       = state_r;
    cnt_n         = cnt_r;
    idx_n         = idx_r;
    shift_n       = shift_r;
    mode_n        = mode_r;
    perr_n        = perr_r;
    data_n        = rx_data;
    valid_n       = 1'b0;
    parity_err_n  = parity_err;
    framing_err_n = framing_err;

    if (tick) begin
      case (state_r)
        IDLE: begin
          cnt_n = '0;
          if (!rx_s) state_n = START;
        end
        START: begin
          if (cnt_r == CNT_MID) begin
            cnt_n = '0;
            if (!rx_s) begin
              // Parity config is frozen here so later changes cannot affect this frame.
              mode_n  = parity_mode(parity_en, parity_odd);
              perr_n  = 1'b0;
              idx_n   = '0;
              state_n = DATA;
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt_r + 1'b1;
          end
        end
        DATA: begin
          if (cnt_r == CNT_LAST) begin
            shift_n = {rx_s, shift_r[DATA_BITS-1:1]};
            cnt_n   = '0;
            idx_n   = idx_r + 1'b1;
            if (idx_r == IDX_LAST)
              state_n = (mode_r != PARITY_NONE) ? PARITY : STOP;
          end else begin
            cnt_n = cnt_r + 1'b1;
          end
        end
        PARITY: begin
          if (cnt_r == CNT_LAST) begin
            perr_n  = (^shift_r) ^ rx_s ^ (mode_r == PARITY_ODD);
            cnt_n   = '0;
            state_n = STOP;
          end else begin
            cnt_n = cnt_r + 1'b1;
          end
        end
        STOP: begin
          if (cnt_r == CNT_LAST) begin
            data_n        = shift_r;
            valid_n       = 1'b1;
            parity_err_n  = perr_r;
            framing_err_n = ~rx_s;
            cnt_n         = '0;
            state_n       = rx_s ? IDLE : BREAK_WAIT;
          end else begin
            cnt_n = cnt_r + 1'b1;
          end
        end
        BREAK_WAIT: begin
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler: 54-clk rx_clk, 432-clk bit cells.
module tb_uart_rx_oversampler;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_clk = 1'b0;
  logic       rx_in = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, framing_err, busy;

  int checks = 0;
  int fails = 0;
  int valid_cnt = 0;
  int run_len = 0;
  int max_run = 0;
  logic [7:0] rx_q[$];

  uart_rx_oversampler #(.DATA_BITS(8), .OVERSAMPLE(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_clk      (rx_clk),
    .rx_in       (rx_in),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .busy        (busy)
  );

  always #10 clk = ~clk;

  always begin
    #540 rx_clk = 1'b1;
    #540 rx_clk = 1'b0;
  end

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      rx_q.push_back(rx_data);
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    wait_clks(432);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par_on,
                            input logic par_bit, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (par_on) send_bit(par_bit);
    send_bit(stop_bit);
  endtask

  initial begin
    int base;
    wait_clks(5);
    #1;
    check("reset_data", rx_data, 8'h00);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_perr", parity_err, 1'b0);
    check("reset_ferr", framing_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    wait_clks(200);

    // 8N1 0xA5
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check("a5_count", valid_cnt, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_perr", parity_err, 1'b0);
    check("a5_ferr", framing_err, 1'b0);
    check("a5_busy", busy, 1'b0);
    check("a5_pulse_width", max_run, 1);
    wait_clks(432);

    // Glitch shorter than half a bit
    rx_in = 1'b0;
    wait_clks(100);
    rx_in = 1'b1;
    wait_clks(600);
    check("glitch_count", valid_cnt, 1);
    check("glitch_data", rx_data, 8'hA5);
    check("glitch_busy", busy, 1'b0);

    // Parity frames
    parity_en = 1'b1;
    parity_odd = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
    wait_clks(432);
    check("even_ok_count", valid_cnt, 2);
    check("even_ok_data", rx_data, 8'h5A);
    check("even_ok_perr", parity_err, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
    wait_clks(432);
    check("even_bad_count", valid_cnt, 3);
    check("even_bad_perr", parity_err, 1'b1);
    parity_odd = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
    wait_clks(432);
    check("odd_ok_count", valid_cnt, 4);
    check("odd_ok_perr", parity_err, 1'b0);
    check("odd_ok_ferr", framing_err, 1'b0);

    // Framing error followed by a held-low line
    parity_en = 1'b0;
    parity_odd = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_clks(5000);
    check("brk_count", valid_cnt, 5);
    check("brk_data", rx_data, 8'h3C);
    check("brk_ferr", framing_err, 1'b1);
    check("brk_perr", parity_err, 1'b0);
    check("brk_state", dut.state_r, BREAK_WAIT);
    check("brk_busy", busy, 1'b1);
    rx_in = 1'b1;
    wait_clks(432);
    check("brk_release_busy", busy, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    wait_clks(432);
    check("after_brk_count", valid_cnt, 6);
    check("after_brk_data", rx_data, 8'h11);
    check("after_brk_ferr", framing_err, 1'b0);

    // Back-to-back frames
    base = rx_q.size();
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    wait_clks(432);
    check("b2b_count", valid_cnt, 9);
    check("b2b_q_size", rx_q.size(), base + 3);
    if (rx_q.size() >= base + 3) begin
      check("b2b_first", rx_q[base], 8'h00);
      check("b2b_second", rx_q[base+1], 8'hFF);
      check("b2b_third", rx_q[base+2], 8'h81);
    end
    check("b2b_pulse_width", max_run, 1);

    // Reset during data bit 3
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx_in = 1'b1;
    wait_clks(216);
    check("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_data", rx_data, 8'h00);
    check("mid_rst_valid", rx_valid, 1'b0);
    check("mid_rst_perr", parity_err, 1'b0);
    check("mid_rst_ferr", framing_err, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    wait_clks(3);
    reset = 1'b0;
    wait_clks(864);
    check("post_rst_count", valid_cnt, 9);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
    wait_clks(432);
    check("post_rst_frame_count", valid_cnt, 10);
    check("post_rst_data", rx_data, 8'h7E);
    check("post_rst_ferr", framing_err, 1'b0);
    check("final_pulse_width", max_run, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampler.md
Name: uart_rx_oversampler

Overview:
- Serial receiver directly downstream of the baud generator.
- Consumes the generator's square-wave rx_clk, an 8x-oversample clock relative to the Tx bit rate, and recovers 8N1 / 8E1 / 8O1 frames from the rx_in line.
- Runs entirely in the clk domain: rx_clk is synchronised and edge-detected into a one-cycle sample tick, never used as a clock.
- Delivers each received byte with a one-cycle valid strobe plus parity and framing status.

Parameters:
- DATA_BITS, 8, data bits per frame, sent LSB first.
- OVERSAMPLE, 8, rx_clk rising edges per bit period.
- SYNC_STAGES, 2, flip-flop depth of the rx_in and rx_clk synchronisers (minimum 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_clk  in  1  oversample square wave from the baud generator.
- rx_in  in  1  serial line, idle high.
- parity_en  in  1  1 = frame carries a parity bit.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- rx_data  out  DATA_BITS  last received byte.
- rx_valid  out  1  one-clk pulse when a frame completes.
- parity_err  out  1  status of the last frame.
- framing_err  out  1  status of the last frame (stop bit sampled 0).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, parity_err=0, framing_err=0, busy=0; state=IDLE; counters 0; synchroniser flops=1 for rx_in and 0 for rx_clk.
- Reset mid-frame aborts immediately; there is no partial output.
- Tick generation: tick=1 for exactly one clk on each synchronised 0->1 transition of rx_clk. All FSM activity below happens only on tick cycles.
- rx_s denotes the synchronised rx_in.
- Sample counter cnt has width clog2(OVERSAMPLE); bit_idx has width clog2(DATA_BITS).
- IDLE: on tick with rx_s=0 -> START, cnt=0.
- START: cnt increments each tick. At cnt=OVERSAMPLE/2-1 (mid start bit):
  - rx_s=0: latch parity_en and parity_odd, cnt=0, bit_idx=0 -> DATA.
  - rx_s=1: glitch -> IDLE with no status change.
- DATA: at cnt=OVERSAMPLE-1, shift rx_s into the shift register MSB (LSB arrives first), cnt=0, bit_idx++. After bit DATA_BITS-1 -> PARITY if the latched parity_en=1, else STOP.
- PARITY: at cnt=OVERSAMPLE-1, compute perr = XOR(data bits, sampled bit, latched parity_odd); cnt=0 -> STOP. When parity is disabled, perr=0.
- STOP: at cnt=OVERSAMPLE-1, on the next clk:
  - rx_data <= shift register.
  - rx_valid <= 1 for one clk.
  - parity_err <= perr.
  - framing_err <= ~rx_s.
  - Go to IDLE if rx_s=1, else BREAK_WAIT.
- BREAK_WAIT: stay until a tick with rx_s=1 -> IDLE. This prevents a held-low line (break) from retriggering reception.
- rx_valid pulses on every completed frame, including erroneous ones; the consumer qualifies it with the error flags.
- rx_data and the error flags hold until the next frame completes.
- Latency:
  - rx_in edge to tick-domain visibility: SYNC_STAGES clk.
  - rx_valid: 1 clk after the tick that samples the stop bit.
- Parity config changes mid-frame have no effect on that frame, because the values are latched at start confirmation.
- A tick and a reset in the same cycle: reset wins.
- rx_clk stopped: the FSM freezes in its current state; no timeout.

Decomposition:
- Shared package uart_pkg:
  - rx state enum: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - Default constants DATA_BITS=8 and OVERSAMPLE=8.
  - Parity-mode encoding shared with the future transmitter.
- One natural sub-module, uart_sync_edge: an N-stage synchroniser with a rising-edge pulse output. It is instanced twice:
  - For rx_clk, using its edge output as tick.
  - For rx_in, using its level output.

Test Plan:
- Setup for all scenarios: clk 50 MHz, baud generator at the 115200 setting (Tx_k=217, Rx_k=27), giving an rx_clk period of 54 clk. The bench drives bits at 432 clk per bit.
- 8N1 frame for 0xA5 -> rx_data=0xA5; rx_valid high exactly 1 clk; parity_err=0, framing_err=0; busy returns to 0 after the stop bit.
- Glitch: rx_in low for 100 clk, then high -> START aborts to IDLE; no rx_valid; rx_data unchanged.
- Even parity, 0x5A with parity bit 0 -> parity_err=0. Same frame with parity bit 1 -> parity_err=1 and rx_valid still pulses. Odd parity, 0x5A with parity bit 1 -> parity_err=0.
- 0x3C frame with stop bit 0 and the line held low 5000 clk -> framing_err=1, state BREAK_WAIT, no second rx_valid. After the line rises, the next 0x11 frame gives rx_data=0x11 and framing_err=0.
- Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap -> three rx_valid pulses with the matching data, in order.
- Reset asserted during data bit 3 of a frame -> all outputs are 0 in the same cycle. The following clean 0x7E frame gives rx_data=0x7E.
